// File: rtl/tm_pkg.sv
// Shared types and constants for the programmable Turing machine tile.
// Rules are stored as five consecutive 4-bit program words.
package tm_pkg;

  localparam int DATA_W         = 4;
  localparam int PROG_DEPTH     = 64;
  localparam int TAPE_LEN       = 32;
  localparam int WORDS_PER_RULE = 5;
  localparam int MAX_RULES      = PROG_DEPTH / WORDS_PER_RULE;
  localparam int PTR_W          = 7;
  localparam int MEM_AW         = 6;
  localparam int HEAD_W         = 5;
  localparam int RCNT_W         = 4;
  localparam int DISP_W         = 11;
  localparam int DISP_HALF      = 5;

  localparam logic [DATA_W-1:0] HALT_STATE = 4'hF;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } phase_e;

  typedef enum logic [1:0] {
    MOVE_L = 2'd0,
    MOVE_R = 2'd1,
    MOVE_S = 2'd2
  } move_e;

  typedef struct packed {
    logic [DATA_W-1:0] cur_state;
    logic [DATA_W-1:0] read_sym;
    logic [DATA_W-1:0] write_sym;
    logic [DATA_W-1:0] move;
    logic [DATA_W-1:0] next_state;
  } rule_t;

  // Move words 2, 3 and anything undefined all mean "stay".
  function automatic move_e decode_move(input logic [DATA_W-1:0] w);
    case (w)
      4'd0:    return MOVE_L;
      4'd1:    return MOVE_R;
      default: return MOVE_S;
    endcase
  endfunction

endpackage

// File: rtl/tm_rule_match.sv
// Parallel priority matcher: every loaded rule is compared against
// (state, symbol) at once and the lowest-index hit wins.
module tm_rule_match
  import tm_pkg::*;
(
  input  rule_t [MAX_RULES-1:0] rules_i,
  input  logic  [RCNT_W-1:0]    rule_cnt_i,
  input  logic  [DATA_W-1:0]    state_i,
  input  logic  [DATA_W-1:0]    sym_i,
  output logic                  hit_o,
  output logic  [DATA_W-1:0]    write_sym_o,
  output move_e                 move_o,
  output logic  [DATA_W-1:0]    next_state_o
);

  logic [MAX_RULES-1:0] match_s;

  // Descending scan so that the lowest matching index is assigned last.
  always_comb begin
    hit_o        = 1'b0;
    write_sym_o  = '0;
    move_o       = MOVE_S;
    next_state_o = '0;
    for (int i = MAX_RULES - 1; i >= 0; i--) begin
      match_s[i] = (i < int'(rule_cnt_i)) &&
                   (rules_i[i].cur_state == state_i) &&
                   (rules_i[i].read_sym == sym_i);
      if (match_s[i]) begin
        hit_o        = 1'b1;
        write_sym_o  = rules_i[i].write_sym;
        move_o       = decode_move(rules_i[i].move);
        next_state_o = rules_i[i].next_state;
      end else begin
        hit_o        = hit_o;
      end
    end
  end

endmodule

// File: rtl/turing_machine.sv
// Single-tape programmable Turing machine: LOAD program words, RUN steps, HALT.
// Define TM_AUTORUN_EN to step every clock in RUN instead of once per Next rise.
module turing_machine
  import tm_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] input_data,
  input  logic              Next,
  input  logic              Done,
  output logic [DISP_W-1:0] display_out,
  output logic [DATA_W-1:0] currState,
  output logic [DATA_W-1:0] read_data,
  output logic              Compute_done
);

  phase_e            phase_q, phase_d;
  logic              next_q;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [RCNT_W-1:0] rule_cnt_q, rule_cnt_d;
  logic [HEAD_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] state_q, state_d;
  logic [DATA_W-1:0] mem_q  [PROG_DEPTH];
  logic [DATA_W-1:0] tape_q [TAPE_LEN];

  logic                  rise_s;
  logic                  step_s;
  logic                  load_wr_s;
  logic                  tape_wr_s;
  logic [DATA_W-1:0]     sym_s;
  rule_t [MAX_RULES-1:0] rules_s;
  logic                  hit_s;
  logic [DATA_W-1:0]     m_write_s;
  move_e                 m_move_s;
  logic [DATA_W-1:0]     m_next_s;

  assign rise_s    = Next & ~next_q;
  assign load_wr_s = (phase_q == LOAD) && rise_s && (wr_ptr_q < PTR_W'(PROG_DEPTH));
  assign sym_s     = tape_q[head_q];
  assign tape_wr_s = step_s & hit_s;

`ifdef TM_AUTORUN_EN
  assign step_s = (phase_q == RUN);
`else
  assign step_s = (phase_q == RUN) && rise_s;
`endif

  // Rules are just a view of the program memory, five words apiece.
  always_comb begin
    for (int i = 0; i < MAX_RULES; i++) begin
      rules_s[i].cur_state  = mem_q[MEM_AW'(i * WORDS_PER_RULE)];
      rules_s[i].read_sym   = mem_q[MEM_AW'(i * WORDS_PER_RULE + 1)];
      rules_s[i].write_sym  = mem_q[MEM_AW'(i * WORDS_PER_RULE + 2)];
      rules_s[i].move       = mem_q[MEM_AW'(i * WORDS_PER_RULE + 3)];
      rules_s[i].next_state = mem_q[MEM_AW'(i * WORDS_PER_RULE + 4)];
    end
  end

  tm_rule_match u_match (
    .rules_i      (rules_s),
    .rule_cnt_i   (rule_cnt_q),
    .state_i      (state_q),
    .sym_i        (sym_s),
    .hit_o        (hit_s),
    .write_sym_o  (m_write_s),
    .move_o       (m_move_s),
    .next_state_o (m_next_s)
  );

  // Phase register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase_q <= LOAD;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Phase transitions; a missing rule or a HALT_STATE target ends the run.
  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      LOAD: begin
        if (Done) phase_d = RUN;
        else      phase_d = LOAD;
      end
      RUN: begin
        if (step_s && (!hit_s || (m_next_s == HALT_STATE))) phase_d = HALT;
        else                                                phase_d = RUN;
      end
      HALT:    phase_d = HALT;
      default: phase_d = LOAD;
    endcase
  end

  // Phase-derived outputs and the tape window around the head.
  always_comb begin
    Compute_done = (phase_q == HALT);
    currState    = state_q;
    read_data    = sym_s;
    display_out  = '0;
    for (int k = -DISP_HALF; k <= DISP_HALF; k++) begin
      int idx;
      idx = int'(head_q) + k;
      if ((idx >= 0) && (idx < TAPE_LEN)) display_out[DISP_HALF + k] = |tape_q[idx[HEAD_W-1:0]];
      else                                display_out[DISP_HALF + k] = 1'b0;
    end
  end

  // Next-state of pointer, rule count, head and machine state.
  always_comb begin
    wr_ptr_d   = wr_ptr_q + PTR_W'(load_wr_s);
    rule_cnt_d = rule_cnt_q;
    head_d     = head_q;
    state_d    = state_q;
    if ((phase_q == LOAD) && Done) begin
      rule_cnt_d = RCNT_W'(wr_ptr_d / PTR_W'(WORDS_PER_RULE));
    end else begin
      rule_cnt_d = rule_cnt_q;
    end
    if (tape_wr_s) begin
      state_d = m_next_s;
      case (m_move_s)
        MOVE_L:  head_d = (head_q != '0) ? head_q - 5'd1 : head_q;
        MOVE_R:  head_d = (head_q != HEAD_W'(TAPE_LEN - 1)) ? head_q + 5'd1 : head_q;
        default: head_d = head_q;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Scalar registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      next_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rule_cnt_q <= '0;
      head_q     <= HEAD_W'(TAPE_LEN / 2);
      state_q    <= '0;
    end else begin
      next_q     <= Next;
      wr_ptr_q   <= wr_ptr_d;
      rule_cnt_q <= rule_cnt_d;
      head_q     <= head_d;
      state_q    <= state_d;
    end
  end

  // Program memory.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PROG_DEPTH; i++) mem_q[i] <= '0;
    end else if (load_wr_s) begin
      mem_q[wr_ptr_q[MEM_AW-1:0]] <= input_data;
    end
  end

  // Tape storage.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TAPE_LEN; i++) tape_q[i] <= '0;
    end else if (tape_wr_s) begin
      tape_q[head_q] <= m_write_s;
    end
  end

endmodule

// File: tb/tb_turing_machine.sv
// Self-checking bench: directed scenarios plus random programs against a
// queue-based reference model of the Turing machine.
module tb_turing_machine;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  input_data;
  logic        Next;
  logic        Done;
  logic [10:0] display_out;
  logic [3:0]  currState;
  logic [3:0]  read_data;
  logic        Compute_done;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: program words, tape, head, state, phase (0 load, 1 run, 2 halt).
  int m_prog[$];
  int m_tape[32];
  int m_head, m_state, m_phase, m_rcnt;

  always #5 clock = ~clock;

  turing_machine dut (
    .clock        (clock),
    .reset        (reset),
    .input_data   (input_data),
    .Next         (Next),
    .Done         (Done),
    .display_out  (display_out),
    .currState    (currState),
    .read_data    (read_data),
    .Compute_done (Compute_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prog.delete();
    for (int i = 0; i < 32; i++) m_tape[i] = 0;
    m_head = 16; m_state = 0; m_phase = 0; m_rcnt = 0;
  endtask

  task automatic model_next(input int w);
    int found;
    if (m_phase == 0) begin
      if (m_prog.size() < 64) m_prog.push_back(w);
    end else if (m_phase == 1) begin
      found = -1;
      for (int r = 0; r < m_rcnt && found < 0; r++)
        if (m_prog[5*r] == m_state && m_prog[5*r+1] == m_tape[m_head]) found = r;
      if (found < 0) begin
        m_phase = 2;
      end else begin
        m_tape[m_head] = m_prog[5*found+2];
        if (m_prog[5*found+3] == 0 && m_head > 0) m_head--;
        else if (m_prog[5*found+3] == 1 && m_head < 31) m_head++;
        m_state = m_prog[5*found+4];
        if (m_state == 15) m_phase = 2;
      end
    end
  endtask

  task automatic model_done();
    if (m_phase == 0) begin
      m_rcnt  = m_prog.size() / 5;
      m_phase = 1;
    end
  endtask

  function automatic logic [10:0] model_disp();
    logic [10:0] d;
    d = '0;
    for (int k = -5; k <= 5; k++) begin
      int idx;
      idx = m_head + k;
      if (idx >= 0 && idx < 32) d[5+k] = (m_tape[idx] != 0);
    end
    return d;
  endfunction

  task automatic check_all(input string tag);
    check_eq({tag, "/disp"},  32'(display_out),  32'(model_disp()));
    check_eq({tag, "/state"}, 32'(currState),    32'(m_state));
    check_eq({tag, "/rdata"}, 32'(read_data),    32'(m_tape[m_head]));
    check_eq({tag, "/cdone"}, 32'(Compute_done), 32'(m_phase == 2));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    Next = 1'b0; Done = 1'b0; input_data = 4'd0;
    reset = 1'b0;
    #1;
    model_reset();
    check_eq("rst/disp",  32'(display_out),  32'd0);
    check_eq("rst/state", 32'(currState),    32'd0);
    check_eq("rst/cdone", 32'(Compute_done), 32'd0);
    check_eq("rst/rdata", 32'(read_data),    32'd0);
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic pulse_next(input int w);
    input_data = 4'(w);
    Next = 1'b1;
    tick();
    model_next(w);
    Next = 1'b0;
    tick();
  endtask

  task automatic pulse_done();
    Done = 1'b1;
    tick();
    model_done();
    Done = 1'b0;
    tick();
  endtask

  task automatic load_words(input int ws[$]);
    foreach (ws[i]) pulse_next(ws[i]);
  endtask

  logic [10:0] bb_exp [6];

  initial begin
    int prog[$];
    reset = 1'b0; Next = 1'b0; Done = 1'b0; input_data = 4'd0;
    bb_exp = '{11'b00000010000, 11'b00001100000, 11'b00011000000,
               11'b00111000000, 11'b00011110000, 11'b00001111000};

    // Simple right-writing rule.
    apply_reset();
    load_words('{0, 0, 1, 1, 0});
    check_all("load");
    check_eq("load/disp0", 32'(display_out), 32'd0);
    pulse_done();
    pulse_next(0);
    check_eq("simple/p1", 32'(display_out), 32'(11'b00000010000));
    pulse_next(0);
    check_eq("simple/p2", 32'(display_out), 32'(11'b00000011000));
    check_eq("simple/cd", 32'(Compute_done), 32'd0);
    check_all("simple");

    // Reset in the middle of RUN.
    reset = 1'b0;
    #1;
    model_reset();
    check_eq("midrst/disp",  32'(display_out),  32'd0);
    check_eq("midrst/state", 32'(currState),    32'd0);
    check_eq("midrst/cdone", 32'(Compute_done), 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // Busy beaver, loaded straight after the mid-run reset.
    load_words('{0,0,1,1,1, 0,1,1,0,1, 1,0,1,0,0, 1,1,1,1,15});
    pulse_done();
    for (int i = 0; i < 6; i++) begin
      pulse_next(0);
      check_eq($sformatf("bb/disp%0d", i), 32'(display_out), 32'(bb_exp[i]));
      check_eq($sformatf("bb/cd%0d", i), 32'(Compute_done), 32'(i == 5));
      check_all($sformatf("bb%0d", i));
    end
    for (int i = 0; i < 3; i++) begin
      pulse_next(0);
      pulse_done();
      check_eq("halt/disp", 32'(display_out), 32'(11'b00001111000));
      check_all("halt");
    end

    // No rule matches the initial symbol.
    apply_reset();
    load_words('{0, 1, 1, 1, 0});
    pulse_done();
    pulse_next(0);
    check_eq("nomatch/cd",   32'(Compute_done), 32'd1);
    check_eq("nomatch/disp", 32'(display_out),  32'd0);
    check_all("nomatch");

    // Next held high for 6 cycles writes exactly one word.
    apply_reset();
    input_data = 4'd0;
    Next = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    model_next(0);
    Next = 1'b0;
    tick();
    load_words('{0, 1, 1, 0});
    pulse_done();
    pulse_next(0);
    check_eq("hold/disp", 32'(display_out), 32'(11'b00000010000));
    check_all("hold");

    // Head pinned at the right edge, then the left edge.
    apply_reset();
    load_words('{0,0,1,1,0, 0,1,1,1,0});
    pulse_done();
    for (int i = 0; i < 20; i++) pulse_next(0);
    check_eq("edgeR/disp", 32'(display_out), 32'(11'b00000111111));
    check_all("edgeR");
    apply_reset();
    load_words('{0,0,1,0,0, 0,1,1,0,0});
    pulse_done();
    for (int i = 0; i < 20; i++) pulse_next(0);
    check_eq("edgeL/disp", 32'(display_out), 32'(11'b11111100000));
    check_all("edgeL");

    // Random programs, including word/Done collisions and memory overflow.
    for (int t = 0; t < 30; t++) begin
      int nrules, mode;
      apply_reset();
      prog.delete();
      mode = $urandom_range(0, 3);
      if (mode == 3) begin
        for (int i = 0; i < 67; i++) prog.push_back($urandom_range(0, 15));
      end else begin
        nrules = $urandom_range(1, 12);
        for (int r = 0; r < nrules; r++) begin
          int ns;
          prog.push_back($urandom_range(0, 2));
          prog.push_back($urandom_range(0, 1));
          prog.push_back($urandom_range(0, 1));
          prog.push_back($urandom_range(0, 3));
          ns = $urandom_range(0, 3);
          prog.push_back(ns == 3 ? 15 : ns);
        end
        if (nrules < 12) for (int i = $urandom_range(0, 4); i > 0; i--) prog.push_back($urandom_range(0, 15));
      end
      if (mode == 1) begin
        for (int i = 0; i < prog.size() - 1; i++) pulse_next(prog[i]);
        input_data = 4'(prog[prog.size() - 1]);
        Next = 1'b1; Done = 1'b1;
        tick();
        model_next(prog[prog.size() - 1]);
        model_done();
        Next = 1'b0; Done = 1'b0;
        tick();
      end else begin
        load_words(prog);
        pulse_done();
      end
      check_all($sformatf("rnd%0d/start", t));
      for (int s = 0; s < 25; s++) begin
        pulse_next($urandom_range(0, 15));
        check_all($sformatf("rnd%0d/s%0d", t, s));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
